// File: rtl/spi_transmit.sv
// SPI mode-0 slave transmitter with a push FIFO, oversampled in the clk domain.
// Optional sticky underrun flag: define SPI_TX_UNDERRUN_EN.
module spi_transmit #(
  parameter int messageBits = 8,
  parameter int fifoDepth   = 4
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   sck,
  input  logic                   cs,
  output logic                   sdo,
  input  logic [messageBits-1:0] txData,
  input  logic                   txValid,
  output logic                   txReady,
  output logic                   busy
`ifdef SPI_TX_UNDERRUN_EN
  ,
  output logic                   underrun
`endif
);

  localparam int cntW  = $clog2(messageBits + 1);
  localparam int ptrW  = $clog2(fifoDepth);
  localparam int fillW = $clog2(fifoDepth + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [2:0] sckSync;
  logic [2:0] csSync;
  logic       sckRise;
  logic       sckFall;
  logic       csRise;
  logic       csFall;

  logic [messageBits-1:0] mem [fifoDepth];
  logic [ptrW-1:0]        wrPtr;
  logic [ptrW-1:0]        rdPtr;
  logic [fillW-1:0]       count;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  logic [0:0]             state;
  logic [messageBits-1:0] shiftReg;
  logic [cntW-1:0]        bitCount;
  logic                   load;
  logic [messageBits-1:0] loadWord;

  // two-flop synchronizers plus a history flop for edge detection
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sckSync <= '0;
      csSync  <= '0;
    end else begin
      sckSync <= {sckSync[1:0], sck};
      csSync  <= {csSync[1:0], cs};
    end
  end

  assign sckRise = sckSync[1] & ~sckSync[2];
  assign sckFall = ~sckSync[1] & sckSync[2];
  assign csRise  = csSync[1] & ~csSync[2];
  assign csFall  = ~csSync[1] & csSync[2];
  assign busy    = csSync[1];

  assign full    = (count == fillW'(fifoDepth));
  assign empty   = (count == '0);
  assign txReady = ~full;
  assign push    = txValid & ~full;
  assign pop     = load & ~empty;

  assign loadWord = empty ? '0 : mem[rdPtr];

  // load request: frame start, or word boundary unless cs is dropping
  always_comb begin
    load = 1'b0;
    if (state == IDLE)
      load = csRise;
    else
      load = ~csFall & sckFall &
             (bitCount == cntW'(messageBits));
  end

  // FIFO storage, pointers and fill count
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < fifoDepth; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= txData;
        wrPtr      <= wrPtr + ptrW'(1);
      end
      if (pop)
        rdPtr <= rdPtr + ptrW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + fillW'(1);
        2'b01:   count <= count - fillW'(1);
        default: count <= count;
      endcase
    end
  end

  // frame state machine and shift register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      shiftReg <= '0;
      bitCount <= '0;
    end else if (state == IDLE) begin
      bitCount <= '0;
      if (csRise) begin
        state    <= SHIFT;
        shiftReg <= loadWord;
      end
    end else begin
      if (csFall) begin
        state    <= IDLE;
        bitCount <= '0;
      end else if (sckRise) begin
        bitCount <= bitCount + cntW'(1);
      end else if (sckFall) begin
        if (load) begin
          shiftReg <= loadWord;
          bitCount <= '0;
        end else begin
          shiftReg <= shiftReg << 1;
        end
      end
    end
  end

  assign sdo = (state == SHIFT) & shiftReg[messageBits-1];

`ifdef SPI_TX_UNDERRUN_EN
  // sticky: set by an empty load, cleared by a frame that starts with data
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)
      underrun <= 1'b0;
    else if (load && empty)
      underrun <= 1'b1;
    else if (state == IDLE && csRise && !empty)
      underrun <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_spi_transmit.sv
// Bench for spi_transmit: table vectors, corner sequences, random frames
// checked against a queue-based model of the transmitter.
module tb_spi_transmit;

  logic       clk;
  logic       nRst;
  logic       sck;
  logic       cs;
  logic       sdo;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic       busy;
`ifdef SPI_TX_UNDERRUN_EN
  logic       underrun;
`endif

  int nChecks;
  int nFails;

  logic [7:0] q [$];
  logic       modelUnd;

  typedef struct {
    logic [7:0]  w [5];
    int          n;
    int          bits;
    logic [31:0] exp;
    logic        und;
  } vec_t;

  vec_t tbl [4];

  spi_transmit #(.messageBits(8), .fifoDepth(4)) dut (
    .clk     (clk),
    .nRst    (nRst),
    .sck     (sck),
    .cs      (cs),
    .sdo     (sdo),
    .txData  (txData),
    .txValid (txValid),
    .txReady (txReady),
    .busy    (busy)
`ifdef SPI_TX_UNDERRUN_EN
    ,
    .underrun(underrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // expected stream: one word per 8 bits, zero fill when queue is empty
  function automatic logic [31:0] modelFrame(input int nbits);
    logic [31:0] s;
    logic [7:0]  w;
    s = '0;
    w = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i % 8 == 0) begin
        if (q.size() > 0) begin
          w = q.pop_front();
          if (i == 0) modelUnd = 1'b0;
        end else begin
          w = 8'h00;
          modelUnd = 1'b1;
        end
      end
      s = {s[30:0], w[7 - (i % 8)]};
    end
    return s;
  endfunction

  task automatic pushWords(input logic [7:0] w [5], input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      txValid = 1'b1;
      txData  = w[i];
      chk("txReady", {31'b0, txReady}, {31'b0, q.size() < 4});
      @(posedge clk);
      if (q.size() < 4) q.push_back(w[i]);
    end
    @(negedge clk);
    txValid = 1'b0;
  endtask

  // master: sample on sck rise, final sck fall coincides with cs fall
  task automatic runFrame(input int nbits, output logic [31:0] got);
    got = '0;
    @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    chk("busyHigh", {31'b0, busy}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      sck = 1'b1;
      got = {got[30:0], sdo};
      repeat (4) @(negedge clk);
      sck = 1'b0;
      if (i == nbits - 1) cs = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("busyLow", {31'b0, busy}, 32'd0);
    chk("sdoIdle", {31'b0, sdo}, 32'd0);
  endtask

  task automatic checkFlags(input string tag);
    chk({tag, "_txReady"}, {31'b0, txReady}, {31'b0, q.size() < 4});
`ifdef SPI_TX_UNDERRUN_EN
    chk({tag, "_underrun"}, {31'b0, underrun}, {31'b0, modelUnd});
`endif
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] exp;
    logic [7:0]  w [5];
    int          n;
    int          bits;

    nChecks  = 0;
    nFails   = 0;
    modelUnd = 1'b0;
    nRst     = 1'b0;
    sck      = 1'b0;
    cs       = 1'b0;
    txValid  = 1'b0;
    txData   = '0;

    tbl[0] = '{w: '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, bits: 8,
               exp: 32'h000000A5, und: 1'b0};
    tbl[1] = '{w: '{8'h3C, 8'hFF, 8'h01, 8'h00, 8'h00}, n: 3, bits: 24,
               exp: 32'h003CFF01, und: 1'b0};
    tbl[2] = '{w: '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, n: 5, bits: 32,
               exp: 32'h11223344, und: 1'b0};
    tbl[3] = '{w: '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, bits: 16,
               exp: 32'h00008100, und: 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_sdo", {31'b0, sdo}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_txReady", {31'b0, txReady}, 32'd1);
`ifdef SPI_TX_UNDERRUN_EN
    chk("rst_underrun", {31'b0, underrun}, 32'd0);
`endif
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      pushWords(tbl[v].w, tbl[v].n);
      if (tbl[v].n == 5)
        chk("fullReady", {31'b0, txReady}, 32'd0);
      exp = modelFrame(tbl[v].bits);
      runFrame(tbl[v].bits, got);
      chk($sformatf("vec%0d_stream", v), got, tbl[v].exp);
      chk($sformatf("vec%0d_model", v), exp, tbl[v].exp);
`ifdef SPI_TX_UNDERRUN_EN
      chk($sformatf("vec%0d_und", v), {31'b0, underrun},
          {31'b0, tbl[v].und});
`endif
      checkFlags($sformatf("vec%0d", v));
    end

    // abort after 4 bits, then a fresh frame
    w = '{8'hF0, 8'h0F, 8'h00, 8'h00, 8'h00};
    pushWords(w, 2);
    exp = modelFrame(4);
    runFrame(4, got);
    chk("abort_first", got, 32'h0000000F);
    chk("abort_model", got, exp);
    exp = modelFrame(8);
    runFrame(8, got);
    chk("abort_second", got, 32'h0000000F);
    checkFlags("abort");

    // reset during bit 3 of 0x55 with two more words queued
    w = '{8'h55, 8'h11, 8'h22, 8'h00, 8'h00};
    pushWords(w, 3);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
      repeat (4) @(negedge clk);
    end
    sck = 1'b1;
    repeat (2) @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    chk("rstMid_sdo", {31'b0, sdo}, 32'd0);
    chk("rstMid_busy", {31'b0, busy}, 32'd0);
    chk("rstMid_txReady", {31'b0, txReady}, 32'd1);
    sck = 1'b0;
    cs  = 1'b0;
    q.delete();
    modelUnd = 1'b0;
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    repeat (3) @(negedge clk);
    checkFlags("rstMid");
    exp = modelFrame(8);
    runFrame(8, got);
    chk("rstMid_fill", got, 32'h0);
    chk("rstMid_model", got, exp);
    checkFlags("rstMid_after");

    // random frames against the model
    for (int r = 0; r < 20; r++) begin
      n    = $urandom_range(0, 5);
      bits = $urandom_range(1, 32);
      for (int k = 0; k < 5; k++)
        w[k] = 8'($urandom_range(0, 255));
      pushWords(w, n);
      exp = modelFrame(bits);
      runFrame(bits, got);
      chk($sformatf("rand%0d_stream", r), got, exp);
      checkFlags($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/spi_transmit.md
# spi_transmit

SPI slave transmitter for returning processed pixel bytes from the edge-detection datapath to the MCU. Sits beside the SPI receive path and is fed by the filter/output stage through a valid/ready handshake into an internal FIFO. Serializes each byte MSB-first on `sdo` in SPI mode 0 while the MCU clocks `sck` with `cs` active. Operates entirely in the system clock domain and oversamples `sck` and `cs` through synchronizers.

## Interface
- `messageBits`, 8: bits per transmitted word (1..16).
- `fifoDepth`, 4: FIFO entries; must be a power of two, at least 2.

- `clk` input 1: system clock; must run at least 4× `sck`.
- `nRst` input 1: reset, asynchronous, active-low.
- `sck` input 1: SPI clock from the MCU, asynchronous to `clk`.
- `cs` input 1: frame active, active-high, asynchronous to `clk`.
- `sdo` output 1: serial data to the MCU.
- `txData` input messageBits: word to enqueue.
- `txValid` input 1: `txData` is valid.
- `txReady` output 1: FIFO can accept a word.
- `busy` output 1: a frame is in progress (synchronized `cs` high).
- `underrun` output 1: sticky flag; present only with `SPI_TX_UNDERRUN_EN`.

## Operation
- **Synchronizers:** `sck` and `cs` each pass through 2 flops, plus a third flop for edge detection. All behaviour below refers to the synchronized signals.
- **FIFO:**
  - A push occurs when `txValid && txReady`.
  - `txReady = !full`. It does not depend on a same-cycle pop.
  - Read and write pointers wrap modulo `fifoDepth`. A count register distinguishes full from empty.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push into an empty FIFO is not visible to a pop in the same cycle; there is no bypass.
- **State machine:** states IDLE, SHIFT.
  - IDLE:
    - `sdo = 0`, `bitCount = 0`.
    - On a `cs` rising edge: load the shift register, drive its MSB on `sdo`, go to SHIFT.
  - SHIFT, on an `sck` rising edge: `bitCount++`. The master samples on this edge.
  - SHIFT, on an `sck` falling edge:
    - If `bitCount == messageBits`: load the next word, drive its MSB, `bitCount = 0`.
    - Otherwise: shift left by one and drive the new MSB.
  - SHIFT, on a `cs` falling edge:
    - Go to IDLE and set `sdo = 0`.
    - The remainder of a partially sent word is discarded; it is not re-sent.
    - The FIFO contents are untouched.
- **Load:**
  - If the FIFO is non-empty, pop the head into the shift register.
  - If the FIFO is empty, load all-zero fill and do not pop.
- **Simultaneous events:**
  - A `cs` falling edge takes priority over any `sck` edge detected in the same cycle.
  - Rising and falling `sck` edges cannot coincide because they are separated by synchronizer spacing.
- **bitCount width:** `$clog2(messageBits+1)`.

## Timing
- **Reset values:**
  - `sdo = 0`, `txReady = 1`, `busy = 0`, `underrun = 0`.
  - FIFO empty, state IDLE, shift register 0, `bitCount = 0`.
- **Latency:**
  - `sdo` settles 3 `clk` cycles after an `sck` falling edge.
  - `sdo` settles 3 `clk` cycles after a `cs` rising edge.
  - The MCU must leave at least 4 `clk` cycles between `cs` rising and the first `sck` rising edge.
- **FIFO timing:**
  - A pop updates `txReady` on the next cycle.
  - A push is visible to a load 1 cycle later.
- **`busy`:** equals synchronized `cs`, i.e. a 2-cycle delay.
- **Reset mid-frame:** asynchronous return to the reset values. The FIFO is flushed. `cs` must be deasserted and reasserted before new data is valid.

## Configuration
- **`SPI_TX_UNDERRUN_EN` defined:**
  - The `underrun` port exists.
  - The flag sets on any load that occurs with the FIFO empty.
  - It clears only when a `cs` rising edge finds the FIFO non-empty, or on reset.
- **Undefined:**
  - The `underrun` port and its logic are absent.
  - Empty-FIFO loads still transmit zero fill.

## Test plan
- **Single word:**
  - Stimulus: push 0xA5, assert `cs`, clock 8 `sck` periods at `clk`/8.
  - Required: the master samples 1,0,1,0,0,1,0,1; `txReady` stays 1; with the macro, `underrun = 0`.
- **Back-to-back words:**
  - Stimulus: push 0x3C, 0xFF, 0x01; run one 24-bit frame.
  - Required: the sampled stream is 0x3C, 0xFF, 0x01; the FIFO is empty afterwards.
- **FIFO full (`fifoDepth = 4`):**
  - Stimulus: push 5 words with `cs` low.
  - Required: `txReady` drops after the 4th push; the 5th word is not accepted; a 32-bit frame returns the first 4 words in order.
- **Underrun:**
  - Stimulus: push 0x81 only; run a 16-bit frame.
  - Required: the stream is 0x81 then 0x00; with the macro, `underrun` rises at the second load and stays high after `cs` falls.
- **Abort:**
  - Stimulus: push 0xF0, 0x0F; deassert `cs` after 4 bits; start a new 8-bit frame.
  - Required: the first frame yields 1,1,1,1; the second yields 0x0F; `sdo = 0` between frames.
- **Reset mid-frame:**
  - Stimulus: pulse `nRst` low during bit 3 of 0x55 with 2 words queued.
  - Required: `sdo` and `busy` go to 0 immediately, `txReady = 1`, the FIFO is empty, and the next frame sends zero fill.
